// File: rtl/bcast_pkg.sv
// bcast_pkg: chunk types and arbiter state encoding shared by the broadcaster source arbiter.
package bcast_pkg;
    localparam int BYTE        = 8;
    localparam int CHUNK_BYTES = 1024;
    typedef logic [CHUNK_BYTES-1:0][BYTE-1:0] chunk_t;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, FLUSH} arb_state_e;
endpackage

// File: rtl/bcast_src_arbiter_if.sv
// bcast_src_arbiter_if: source-side and broadcaster-side handshake bundle.
// master = arbiter view, slave = environment (sources + broadcaster) view.
interface bcast_src_arbiter_if #(parameter int NUM_SRC = 4);
    import bcast_pkg::*;
    logic [NUM_SRC-1:0] src_valid, src_last, src_ready, src_req, src_gnt, src_end;
    chunk_t [NUM_SRC-1:0] src_data;
    logic bc_req, bc_chunk_done, bc_done, bc_ready, bc_i_done;
    chunk_t bc_data;
    modport master (
        input  src_valid, src_last, src_ready, src_data, bc_req, bc_chunk_done, bc_done,
        output src_req, src_gnt, src_end, bc_ready, bc_data, bc_i_done
    );
    modport slave (
        output src_valid, src_last, src_ready, src_data, bc_req, bc_chunk_done, bc_done,
        input  src_req, src_gnt, src_end, bc_ready, bc_data, bc_i_done
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above i_ptr with wrap.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SRC_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_onehot,
    output logic [SRC_W-1:0]   o_idx,
    output logic               o_any
);
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int j;
            j = (int'(i_ptr) + k) % NUM_SRC;
            if (!o_any && i_req[j]) begin
                o_any       = 1'b1;
                o_idx       = SRC_W'(j);
                o_onehot[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bcast_src_arbiter.sv
// bcast_src_arbiter: grants one chunk broadcaster to one of NUM_SRC sources per stream, round-robin.
// Optional per-stream chunk and per-source stream counters under BCAST_ARB_STATS_EN.
module bcast_src_arbiter
    import bcast_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
`ifdef BCAST_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                clk,
    input  logic                rstn,
    bcast_src_arbiter_if.master bus,
    output logic                o_busy,
    output logic [SRC_W-1:0]    o_owner
`ifdef BCAST_ARB_STATS_EN
    , output logic [CNT_W-1:0]              o_chunk_cnt,
    output logic [NUM_SRC-1:0][CNT_W-1:0]   o_stream_cnt
`endif
);
    arb_state_e         r_state;
    logic [SRC_W-1:0]   r_owner, r_ptr;
    logic [NUM_SRC-1:0] r_gnt, r_end;
    logic [NUM_SRC-1:0] w_onehot;
    logic [SRC_W-1:0]   w_idx, w_next;
    logic               w_any, w_grant, w_last, w_start, w_stream_end;

    rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
        .i_req(bus.src_valid), .i_ptr(r_ptr),
        .o_onehot(w_onehot), .o_idx(w_idx), .o_any(w_any)
    );

    assign w_grant      = r_state == GRANT;
    assign w_start      = r_state == IDLE && w_any;
    assign w_last       = bus.src_ready[r_owner] & bus.src_last[r_owner];
    // bc_done in GRANT is a protocol error but still closes the stream
    assign w_stream_end = (w_grant || r_state == DRAIN) && bus.bc_done;
    assign w_next       = (r_owner == SRC_W'(NUM_SRC - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_end   <= '0;
        end else begin
            r_end <= '0;
            if (w_start) begin
                r_owner <= w_idx;
                r_gnt   <= w_onehot;
                r_state <= GRANT;
            end else if (w_stream_end) begin
                r_end   <= r_gnt;
                r_ptr   <= w_next;
                r_state <= FLUSH;
            end else if (w_grant && w_last) begin
                r_state <= DRAIN;
            end else if (r_state == FLUSH) begin
                r_gnt   <= '0;
                r_owner <= '0;
                r_state <= IDLE;
            end
        end
    end

    // Handshake is forwarded only while GRANT; DRAIN swallows the trailing bc_req
    assign bus.src_req   = w_grant ? (r_gnt & {NUM_SRC{bus.bc_req}}) : '0;
    assign bus.bc_ready  = w_grant & bus.src_ready[r_owner];
    assign bus.bc_data   = w_grant ? bus.src_data[r_owner] : '0;
    assign bus.bc_i_done = w_grant & w_last;
    assign bus.src_gnt   = r_gnt;
    assign bus.src_end   = r_end;
    assign o_busy        = r_state != IDLE;
    assign o_owner       = r_owner;

`ifdef BCAST_ARB_STATS_EN
    logic [CNT_W-1:0]            r_chunk_cnt;
    logic [NUM_SRC-1:0][CNT_W-1:0] r_stream_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chunk_cnt  <= '0;
            r_stream_cnt <= '0;
        end else begin
            if (w_start)
                r_chunk_cnt <= '0;
            else if (bus.bc_chunk_done && (w_grant || r_state == DRAIN) && !(&r_chunk_cnt))
                r_chunk_cnt <= r_chunk_cnt + 1'b1;
            for (int i = 0; i < NUM_SRC; i++)
                if (r_end[i])
                    r_stream_cnt[i] <= r_stream_cnt[i] + 1'b1;
        end
    end

    assign o_chunk_cnt  = r_chunk_cnt;
    assign o_stream_cnt = r_stream_cnt;
`endif
endmodule

// File: tb/tb_bcast_src_arbiter.sv
// tb_bcast_src_arbiter: directed streams with a scoreboard of expected chunks and src_end pulses.
module tb_bcast_src_arbiter;
    import bcast_pkg::*;

    typedef struct {
        int     own;
        chunk_t data;
        logic   last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic o_busy;
    logic [1:0] o_owner;
    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    logic [3:0] end_q[$];

    bcast_src_arbiter_if #(.NUM_SRC(4)) bif();

`ifdef BCAST_ARB_STATS_EN
    logic [15:0] chunk_cnt;
    logic [3:0][15:0] stream_cnt;
    bcast_src_arbiter #(.NUM_SRC(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bif), .o_busy(o_busy), .o_owner(o_owner),
        .o_chunk_cnt(chunk_cnt), .o_stream_cnt(stream_cnt)
    );
`else
    bcast_src_arbiter #(.NUM_SRC(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bif), .o_busy(o_busy), .o_owner(o_owner)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic chunk_t mk(input int s, input int k);
        chunk_t c;
        for (int b = 0; b < CHUNK_BYTES; b++) c[b] = 8'(s * 37 + k * 11 + b);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every forwarded chunk and every src_end pulse
    always @(negedge clk) begin
        if (rstn) begin
            chk("req_to_non_owner", 32'(bif.src_req & ~bif.src_gnt), 32'd0);
            if (bif.bc_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_chunk", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("chunk_owner", 32'(o_owner), 32'(e.own));
                    chk("bc_i_done", 32'(bif.bc_i_done), 32'(e.last));
                    n_chk++;
                    if (bif.bc_data !== e.data) begin
                        n_fail++;
                        $display("FAIL bc_data: got low word %h expected %h", bif.bc_data[3:0], e.data[3:0]);
                    end
                end
            end
            if (bif.src_end != 0) begin
                if (end_q.size() == 0) chk("unexpected_src_end", 32'(bif.src_end), 32'd0);
                else chk("src_end", 32'(bif.src_end), 32'(end_q.pop_front()));
            end
        end
    end

    task automatic wait_gnt(input int s);
        for (int i = 0; i < 20 && bif.src_gnt == 0; i++) step();
        chk("src_gnt", 32'(bif.src_gnt), 32'(1 << s));
        chk("o_owner", 32'(o_owner), 32'(s));
        chk("o_busy_grant", 32'(o_busy), 32'd1);
    endtask

    task automatic send_chunk(input int s, input int k, input logic last);
        int o;
        o = (s + 1) % 4;
        bif.bc_req = 1'b1;
        #1 chk("src_req_fwd", 32'(bif.src_req), 32'(1 << s));
        step();
        bif.bc_req = 1'b0;
        bif.src_ready[s] = 1'b1;
        bif.src_last[s] = last;
        bif.src_data[s] = mk(s, k);
        bif.src_ready[o] = 1'b1;
        bif.src_data[o] = mk(9, 9);
        exp_q.push_back('{s, mk(s, k), last});
        step();
        bif.src_ready = '0;
        bif.src_last = '0;
        bif.bc_chunk_done = 1'b1;
        step();
        bif.bc_chunk_done = 1'b0;
    endtask

    task automatic finish(input int s, input logic trail, input logic [3:0] keep);
        if (trail) begin
            bif.bc_req = 1'b1;
            #1 chk("drain_req", 32'(bif.src_req), 32'd0);
            chk("drain_ready", 32'(bif.bc_ready), 32'd0);
            step();
        end
        bif.bc_done = 1'b1;
        end_q.push_back(4'(1 << s));
        step();
        bif.bc_done = 1'b0;
        bif.src_valid &= keep;
        #1 chk("flush_busy", 32'(o_busy), 32'd1);
        chk("flush_gnt", 32'(bif.src_gnt), 32'(1 << s));
        chk("flush_req", 32'(bif.src_req), 32'd0);
        step();
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_gnt", 32'(bif.src_gnt), 32'd0);
        chk("idle_owner", 32'(o_owner), 32'd0);
        chk("idle_req", 32'(bif.src_req), 32'd0);
        bif.bc_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        #1 chk("rst_gnt", 32'(bif.src_gnt), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_owner", 32'(o_owner), 32'd0);
        chk("rst_req", 32'(bif.src_req), 32'd0);
        chk("rst_ready", 32'(bif.bc_ready), 32'd0);
        chk("rst_end", 32'(bif.src_end), 32'd0);
        bif.src_valid = '0;
        bif.src_ready = '0;
        bif.bc_req = 1'b0;
        step();
        step();
        chk("rst_end_hold", 32'(bif.src_end), 32'd0);
        rstn = 1'b1;
        step();
    endtask

    initial begin
        bif.src_valid = '0;
        bif.src_last = '0;
        bif.src_ready = '0;
        bif.src_data = '0;
        bif.bc_req = 1'b0;
        bif.bc_chunk_done = 1'b0;
        bif.bc_done = 1'b0;
        step();
        pulse_reset();
        // Single stream on source 0, three chunks
        bif.src_valid = 4'b0001;
        wait_gnt(0);
        for (int k = 0; k < 3; k++) send_chunk(0, k, k == 2);
        finish(0, 1'b0, 4'b1110);
        // Late contenders arrive during source 1's stream; rr_ptr=2 picks source 2
        bif.src_valid = 4'b0010;
        wait_gnt(1);
        send_chunk(1, 0, 1'b0);
        bif.src_valid = 4'b0111;
        send_chunk(1, 1, 1'b1);
        chk("no_switch", 32'(bif.src_gnt), 32'b0010);
        finish(1, 1'b0, 4'b1101);
        // Trailing bc_req after last chunk is absorbed
        wait_gnt(2);
        for (int k = 0; k < 2; k++) send_chunk(2, k, k == 1);
        finish(2, 1'b1, 4'b1011);
        wait_gnt(0);
        send_chunk(0, 0, 1'b1);
        finish(0, 1'b0, 4'b1110);
        // Reset after chunk 2 of 4, with owner handshake active
        bif.src_valid = 4'b0010;
        wait_gnt(1);
        for (int k = 0; k < 2; k++) send_chunk(1, k, 1'b0);
        bif.bc_req = 1'b1;
        bif.src_ready[1] = 1'b1;
        pulse_reset();
        // Round-robin from reset pointer 0
        bif.src_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(n % 4);
            send_chunk(n % 4, 0, 1'b1);
            finish(n % 4, 1'b0, n == 4 ? 4'b0000 : 4'b1111);
        end
        // Single source always re-granted
        bif.src_valid = 4'b0100;
        for (int n = 0; n < 2; n++) begin
            wait_gnt(2);
            send_chunk(2, n, 1'b1);
            finish(2, 1'b0, n == 1 ? 4'b0000 : 4'b1111);
        end
        // Five-chunk stream on source 3 from fresh counters
        pulse_reset();
        bif.src_valid = 4'b1000;
        wait_gnt(3);
        for (int k = 0; k < 5; k++) send_chunk(3, k, k == 4);
        finish(3, 1'b0, 4'b0000);
`ifdef BCAST_ARB_STATS_EN
        chk("chunk_cnt", 32'(chunk_cnt), 32'd5);
        for (int i = 0; i < 4; i++) chk("stream_cnt", 32'(stream_cnt[i]), i == 3 ? 32'd1 : 32'd0);
`endif
        step();
        chk("exp_chunks_left", 32'(exp_q.size()), 32'd0);
        chk("exp_ends_left", 32'(end_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
